fcvt_pipe: RTL and testbench
============================

# fcvt_pipe

Pipelined, handshaked float/int conversion unit for the FPU execution stage. It performs IEEE-754 single-precision ↔ 32-bit two's-complement conversion with full rounding, saturation and special-case handling. It has a fixed 2-cycle latency and accepts one operation per cycle. A destination tag travels with each operation, so the issue logic can retire results without external bookkeeping.

## Interface
- `TAG_W`, default 6: width of the destination tag carried alongside each operation.
- `clk` in 1: the single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous; drops every in-flight operation.
- `in_valid` in 1: the input operation is valid.
- `in_ready` out 1: the unit can accept an operation this cycle.
- `in_op` in 1: selects the conversion; 0 = FTOI (float→int), 1 = ITOF (int→float).
- `in_data` in 32: the operand.
- `in_tag` in TAG_W: destination tag.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out 32: the result.
- `out_tag` out TAG_W: the tag of the operation that produced `out_data`.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready` at a `clk` edge.
  - An output transfer occurs when `out_valid & out_ready`.
- FTOI, with e = `in_data[30:23]` and u = e − 127:
  - e = 255 (Inf/NaN): saturate by sign; positive → 0x7FFFFFFF, negative → 0x80000000.
  - u ≥ 31: saturate by sign. The one exception is 0xCF000000 (−2^31), which returns 0x80000000 exactly.
  - u ≤ −2, including zero and denormals: result is 0.
  - Otherwise: magnitude = {1, frac} shifted by u − 23, rounded to nearest with ties away from zero, then negated if the sign bit is set.
- ITOF:
  - Input 0 → 0x00000000 (+0).
  - Otherwise take magnitude = |in_data| as a 32-bit unsigned value, so 0x80000000 gives 2^31.
  - Normalize the magnitude via leading-zero count, with exponent = 158 − lzc.
  - Keep 24 significant bits. Round to nearest, ties to even, using guard plus sticky bits.
  - A mantissa carry-out increments the exponent and clears the fraction.
- Pipeline stages:
  - S1 (register after input): decode, special-case flags, lzc, alignment shift.
  - S2 (output register): round, sign apply, saturate or pack.
- Elastic pipeline, no bubbles under continuous flow:
  - s2_adv = `~s2_valid | out_ready`.
  - s1_adv = `~s1_valid | s2_adv`.
  - `in_ready` = s1_adv & `~flush`.
- Flush:
  - `flush` clears s1_valid and s2_valid on the next edge.
  - It has priority over any simultaneous input or output transfer, and the input offered in that cycle is not accepted.
- Ordering: results leave in issue order, and each `out_tag` equals the `in_tag` of its operation.

## Timing
- Reset state, asynchronous:
  - s1_valid = s2_valid = 0.
  - `out_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - `in_ready` = 1 as soon as `rstn` is high and `flush` is low.
- Latency: an operation accepted at edge N has `out_valid` high after edge N+2, provided `out_ready` was high at edge N+1.
- Throughput: 1 operation per cycle while `out_ready` = 1.
- Backpressure (`out_valid` & `~out_ready`):
  - `out_data` and `out_tag` hold stable.
  - S1 holds if it is occupied.
  - `in_ready` falls once both stages are full.
- Maximum occupancy is 2 operations. No internal skid buffer is needed, because `in_ready` is combinational from the valid bits and `out_ready`.
- Reset asserted mid-stream: in-flight operations are lost and the outputs return to their reset values immediately.

## Structure
- Package `fcvt_pkg`:
  - `fcvt_op_e` enum (FTOI = 0, ITOF = 1).
  - Constants FP_BIAS = 127, INT_MAX = 32'h7FFFFFFF, INT_MIN = 32'h80000000.
  - Packed struct `fcvt_s1_t` holding the S1 pipeline register: op, sign, special flags, aligned mantissa, guard, sticky, exponent and tag.
- Sub-module `lzc32`: purely combinational 32-bit leading-zero counter with a 6-bit output, where 32 means the input is zero. It is instantiated in S1.

## Test plan
- FTOI rounding:
  - 0x40200000 (2.5) → 0x00000003.
  - 0xC0200000 (−2.5) → 0xFFFFFFFD.
  - 0x3F000000 (0.5) → 0x00000001.
  - 0x3EFFFFFF → 0x00000000.
- FTOI saturation:
  - 0x4F000000 → 0x7FFFFFFF.
  - 0xCF000000 → 0x80000000.
  - 0x7F800000 → 0x7FFFFFFF.
  - 0xFF800000 → 0x80000000.
- ITOF rounding:
  - 0x01000001 → 0x4B800000 (tie, rounds to even).
  - 0x01000003 → 0x4B800002.
  - 0x7FFFFFFF → 0x4F000000 (carry-out).
  - 0x80000000 → 0xCF000000.
  - 0 → 0x00000000.
  - 0xFFFFFFFF → 0xBF800000.
- Backpressure: stream 5 operations with tags 1..5 while `out_ready` = 0 for 4 cycles.
  - `in_ready` drops after 2 acceptances.
  - Results emerge in tag order 1..5 with no loss or duplication.
  - `out_data` is stable while stalled.
- Flush: 2 operations in flight, pulse `flush` together with `in_valid` = 1.
  - Next cycle `out_valid` = 0 and nothing is accepted.
  - The following operation returns its result with 2-cycle latency.
- Reset mid-operation: drop `rstn` asynchronously with both stages full.
  - `out_valid`, `out_data` and `out_tag` go to 0 without waiting for a clock edge.
  - After `rstn` is released, a fresh operation completes normally.

Source files
------------

// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared types and constants for the float/int conversion pipeline.
package fcvt_pkg;

  typedef enum logic {
    FTOI = 1'b0,
    ITOF = 1'b1
  } fcvt_op_e;

  localparam int FP_BIAS = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Tag width stored in the S1 register; the top-level TAG_W must match it.
  localparam int FCVT_TAG_W = 6;

  // FTOI exponent thresholds (biased exponent field).
  // e >= 158 (u >= 31) saturates; this also covers Inf/NaN (e = 255) and
  // -2^31 (0xCF000000), whose negative saturation value is exactly INT_MIN.
  localparam logic [7:0] FTOI_EXP_SAT   = 8'(FP_BIAS + 31);
  // e <= 125 (u <= -2) always rounds to zero.
  localparam logic [7:0] FTOI_EXP_ZERO  = 8'(FP_BIAS - 2);
  // e = 126 (u = -1) corresponds to an alignment shift of zero.
  localparam logic [7:0] FTOI_EXP_SHIFT = 8'(FP_BIAS - 1);

  // ITOF: a magnitude with its MSB at bit 31 has exponent bias + 31.
  localparam logic [7:0] ITOF_EXP_BASE  = 8'(FP_BIAS + 31);

  // S1 pipeline register.
  //   FTOI: mant = integer part, guard = first dropped bit, sticky = rest.
  //   ITOF: mant[23:0] = normalised 24-bit significand, guard/sticky below it,
  //         exp = unrounded biased exponent.
  typedef struct packed {
    fcvt_op_e              op;
    logic                  sign;
    logic                  is_zero;
    logic                  is_sat;
    logic [31:0]           mant;
    logic                  guard;
    logic                  sticky;
    logic [7:0]            exp;
    logic [FCVT_TAG_W-1:0] tag;
  } fcvt_s1_t;

endpackage

// File: rtl/fcvt_pipe_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter; count = 32 for zero input.
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan from LSB to MSB so the highest set bit wins.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fcvt_pipe.sv
// fcvt_pipe: 2-stage elastic float<->int converter with tag passthrough.
module fcvt_pipe
  import fcvt_pkg::*;
#(
  parameter int TAG_W = FCVT_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic     s1_valid;
  logic     s2_valid;
  logic     s1_adv;
  logic     s2_adv;
  fcvt_s1_t s1_d;
  fcvt_s1_t s1_q;

  // Handshake: in_ready depends only on valid bits, out_ready and flush.
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv & ~flush;
  assign out_valid = s2_valid;

  // ---------------- S1 datapath ----------------
  logic [7:0]  f_exp;
  logic [4:0]  f_shamt;
  logic [55:0] f_aligned;
  logic [31:0] i_mag;
  logic [5:0]  i_lzc;
  logic [31:0] i_norm;

  assign f_exp = in_data[30:23];

  lzc32 u_lzc (
    .value (i_mag),
    .count (i_lzc)
  );

  // Alignment for both directions; out-of-range FTOI shifts are masked by flags.
  always_comb begin
    f_shamt   = 5'(f_exp - FTOI_EXP_SHIFT);
    // aligned = value * 2^24: bits [55:24] integer part, [23] guard, [22:0] sticky
    f_aligned = {32'd0, 1'b1, in_data[22:0]} << f_shamt;
    i_mag     = in_data[31] ? (32'd0 - in_data) : in_data;
    i_norm    = i_mag << i_lzc;
  end

  // Decode and special-case flags for the S1 register.
  always_comb begin
    s1_d      = '0;
    s1_d.op   = fcvt_op_e'(in_op);
    s1_d.sign = in_data[31];
    s1_d.tag  = FCVT_TAG_W'(in_tag);
    if (s1_d.op == FTOI) begin
      s1_d.is_sat  = (f_exp >= FTOI_EXP_SAT);
      s1_d.is_zero = (f_exp <= FTOI_EXP_ZERO);
      s1_d.mant    = f_aligned[55:24];
      s1_d.guard   = f_aligned[23];
      s1_d.sticky  = |f_aligned[22:0];
    end else begin
      s1_d.is_zero = (in_data == 32'd0);
      s1_d.mant    = {8'd0, i_norm[31:8]};
      s1_d.guard   = i_norm[7];
      s1_d.sticky  = |i_norm[6:0];
      s1_d.exp     = ITOF_EXP_BASE - {2'b00, i_lzc};
    end
  end

  // S1 register: loads on an input transfer, empties on flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- S2 datapath ----------------
  logic [31:0] ftoi_mag;
  logic        itof_rnd;
  logic        itof_carry;
  logic [22:0] itof_frac;
  logic [31:0] result;

  // Round, apply sign, saturate or pack.
  always_comb begin
    // Ties away from zero: only the first dropped bit matters.
    ftoi_mag   = s1_q.mant + 32'(s1_q.guard);
    // Ties to even on the 24-bit significand. The hidden bit is always 1,
    // so a carry out of the fraction means the significand overflowed.
    itof_rnd   = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
    itof_frac  = s1_q.mant[22:0] + 23'(itof_rnd);
    itof_carry = (&s1_q.mant[22:0]) & itof_rnd;
    result     = 32'd0;
    if (s1_q.op == FTOI) begin
      if (s1_q.is_sat)
        result = s1_q.sign ? INT_MIN : INT_MAX;
      else if (s1_q.is_zero)
        result = 32'd0;
      else
        result = s1_q.sign ? (32'd0 - ftoi_mag) : ftoi_mag;
    end else begin
      if (s1_q.is_zero)
        result = 32'd0;
      else
        result = {s1_q.sign, s1_q.exp + 8'(itof_carry), itof_frac};
    end
  end

  // S2 / output register: holds data and tag while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      out_data <= 32'd0;
      out_tag  <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result;
        out_tag  <= TAG_W'(s1_q.tag);
      end
    end
  end

endmodule

// File: tb/tb_fcvt_pipe.sv
// tb_fcvt_pipe: directed-vector bench for fcvt_pipe.
module tb_fcvt_pipe;

  localparam int TW = 6;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [31:0]   in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;

  fcvt_pipe #(.TAG_W(TW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Single operation with out_ready high: result appears exactly 2 edges later.
  task automatic run_op(input string name, input logic op, input logic [31:0] d,
                        input logic [TW-1:0] tg, input logic [31:0] exp);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_tag   = tg;
    #1;
    chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(tg));
  endtask

  logic        bp_op   [5];
  logic [31:0] bp_data [5];
  logic [31:0] bp_exp  [5];

  initial begin
    int          sent;
    int          got;
    logic        acc;
    logic        ox;
    logic [31:0] cap_data;
    logic [TW-1:0] cap_tag;
    logic        have_prev;
    logic [31:0] prev_data;
    logic [TW-1:0] prev_tag;

    bp_op[0] = 1'b0; bp_data[0] = 32'h4020_0000; bp_exp[0] = 32'h0000_0003;
    bp_op[1] = 1'b1; bp_data[1] = 32'h0100_0003; bp_exp[1] = 32'h4B80_0002;
    bp_op[2] = 1'b0; bp_data[2] = 32'hC020_0000; bp_exp[2] = 32'hFFFF_FFFD;
    bp_op[3] = 1'b1; bp_data[3] = 32'hFFFF_FFFF; bp_exp[3] = 32'hBF80_0000;
    bp_op[4] = 1'b0; bp_data[4] = 32'h3F00_0000; bp_exp[4] = 32'h0000_0001;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 1'b0;
    in_data = 32'd0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_tag",  32'(out_tag), 32'd0);
    #20;
    @(negedge clk); rstn = 1'b1;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // FTOI rounding and saturation
    run_op("f2i_2p5",    1'b0, 32'h4020_0000, 6'd10, 32'h0000_0003);
    run_op("f2i_m2p5",   1'b0, 32'hC020_0000, 6'd11, 32'hFFFF_FFFD);
    run_op("f2i_0p5",    1'b0, 32'h3F00_0000, 6'd12, 32'h0000_0001);
    run_op("f2i_lt0p5",  1'b0, 32'h3EFF_FFFF, 6'd13, 32'h0000_0000);
    run_op("f2i_2p31",   1'b0, 32'h4F00_0000, 6'd14, 32'h7FFF_FFFF);
    run_op("f2i_m2p31",  1'b0, 32'hCF00_0000, 6'd15, 32'h8000_0000);
    run_op("f2i_pinf",   1'b0, 32'h7F80_0000, 6'd16, 32'h7FFF_FFFF);
    run_op("f2i_ninf",   1'b0, 32'hFF80_0000, 6'd17, 32'h8000_0000);
    run_op("f2i_100",    1'b0, 32'h42C8_0000, 6'd18, 32'h0000_0064);

    // ITOF rounding
    run_op("i2f_tie",    1'b1, 32'h0100_0001, 6'd20, 32'h4B80_0000);
    run_op("i2f_up",     1'b1, 32'h0100_0003, 6'd21, 32'h4B80_0002);
    run_op("i2f_carry",  1'b1, 32'h7FFF_FFFF, 6'd22, 32'h4F00_0000);
    run_op("i2f_min",    1'b1, 32'h8000_0000, 6'd23, 32'hCF00_0000);
    run_op("i2f_zero",   1'b1, 32'h0000_0000, 6'd24, 32'h0000_0000);
    run_op("i2f_m1",     1'b1, 32'hFFFF_FFFF, 6'd25, 32'hBF80_0000);
    @(posedge clk); #1;

    // Backpressure: out_ready low for the first 4 cycles, tags 1..5
    sent = 0; got = 0; have_prev = 1'b0; prev_data = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      in_op     = (sent < 5) ? bp_op[sent]   : 1'b0;
      in_data   = (sent < 5) ? bp_data[sent] : 32'd0;
      in_tag    = TW'(sent + 1);
      @(negedge clk);
      if (cyc == 2) begin
        chk("bp_sent2", 32'(sent), 32'd2);
        chk("bp_rdy_low", 32'(in_ready), 32'd0);
      end
      if (out_valid && !out_ready) begin
        if (have_prev) begin
          chk("bp_stable_data", out_data, prev_data);
          chk("bp_stable_tag", 32'(out_tag), 32'(prev_tag));
        end
        have_prev = 1'b1;
        prev_data = out_data;
        prev_tag  = out_tag;
      end
      acc      = in_valid && in_ready;
      ox       = out_valid && out_ready;
      cap_data = out_data;
      cap_tag  = out_tag;
      @(posedge clk); #1;
      if (acc) sent++;
      if (ox) begin
        chk("bp_order", 32'(cap_tag), 32'(got + 1));
        chk("bp_data", cap_data, bp_exp[got]);
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd5);
    chk("bp_sent", 32'(sent), 32'd5);
    @(posedge clk); #1;

    // Flush with two operations in flight and a third offered
    in_valid = 1'b1; in_op = 1'b0; in_data = 32'h4020_0000; in_tag = 6'd30;
    @(posedge clk); #1;
    in_tag = 6'd31;
    @(posedge clk); #1;
    chk("fl_pre_vld", 32'(out_valid), 32'd1);
    flush = 1'b1; in_tag = 6'd32; in_data = 32'h3F00_0000;
    #1;
    chk("fl_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("fl_vld1", 32'(out_valid), 32'd0);
    run_op("fl_after", 1'b1, 32'h0000_0005, 6'd33, 32'h40A0_0000);
    @(posedge clk); #1;

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 1'b1; in_data = 32'h0000_0003; in_tag = 6'd40;
    @(posedge clk); #1;
    in_data = 32'h0000_0007; in_tag = 6'd41;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_pre_vld", 32'(out_valid), 32'd1);
    chk("ar_pre_tag", 32'(out_tag), 32'd40);
    chk("ar_pre_data", out_data, 32'h4040_0000);
    chk("ar_pre_rdy", 32'(in_ready), 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("ar_vld",  32'(out_valid), 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_tag",  32'(out_tag), 32'd0);
    @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar_lost", 32'(out_valid), 32'd0);
    run_op("ar_after", 1'b0, 32'hC2C8_0000, 6'd42, 32'hFFFF_FF9C);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
